// File: rtl/image_window_capture.sv
// image_window_capture: crops (and optionally 2:1 decimates) a sensor
// pixel stream into a FIFO and presents it as a valid/ready stream.
module image_window_capture #(
    parameter int DATA_W     = 8,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int H_OFF      = 0,
    parameter int V_OFF      = 0,
    parameter int FIFO_DEPTH = 1024,
    parameter int CLR_LEN    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pix_vsync,
    input  logic              i_pix_href,
    input  logic              i_pix_en,
    input  logic [DATA_W-1:0] i_pix_data,
    input  logic              i_decim,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_eof,
    output logic              o_frame_clr,
    output logic              o_ovf,
    output logic [15:0]       o_frame_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_W + 3;

    localparam logic [15:0] COL_LO    = 16'(H_OFF);
    localparam logic [15:0] ROW_LO    = 16'(V_OFF);
    localparam logic [15:0] WIN_W     = 16'(IMG_W);
    localparam logic [15:0] WIN_H     = 16'(IMG_H);
    localparam logic [15:0] COL_END_F = 16'(H_OFF + IMG_W - 1);
    localparam logic [15:0] COL_END_D = 16'(H_OFF + IMG_W - 2);
    localparam logic [15:0] ROW_END_F = 16'(V_OFF + IMG_H - 1);
    localparam logic [15:0] ROW_END_D = 16'(V_OFF + IMG_H - 2);
    localparam logic [15:0] CLR_LAST  = 16'(CLR_LEN - 1);
    localparam logic [AW:0] OCC_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              vs_r;
    logic              vs_q;
    logic              hr_r;
    logic              hr_q;
    logic              pe_r;
    logic [DATA_W-1:0] px_r;
    logic              vs_rise;
    logic              hr_fall;

    logic [15:0] col;
    logic [15:0] row;
    logic [15:0] dcol;
    logic [15:0] drow;
    logic [15:0] clr_cnt;
    logic        arm;
    logic        decim_q;
    logic        sof_pend;

    logic        in_win;
    logic        keep;
    logic        eol_hit;
    logic        eof_hit;
    logic        accept;
    logic        flush;

    logic          wp_vld;
    logic [EW-1:0] wp_ent;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   occ;
    logic          mem_empty;
    logic          full;
    logic          xfer;
    logic          load;
    logic          wr_ok;
    logic          drop;

    assign vs_rise = vs_r & ~vs_q;
    assign hr_fall = hr_q & ~hr_r;
    assign flush   = (state_q == S_CLEAR) | vs_rise;

    // Register the sensor inputs once; edges come from the registered copies.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_r <= 1'b0;
            vs_q <= 1'b0;
            hr_r <= 1'b0;
            hr_q <= 1'b0;
            pe_r <= 1'b0;
            px_r <= '0;
        end else begin
            vs_r <= i_pix_vsync;
            vs_q <= vs_r;
            hr_r <= i_pix_href;
            hr_q <= hr_r;
            pe_r <= i_pix_en;
            px_r <= i_pix_data;
        end
    end

    // Column counts pix_en beats in the line, row counts href falls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col <= '0;
            row <= '0;
        end else begin
            if (!hr_r) begin
                col <= '0;
            end else if (pe_r && col != 16'hFFFF) begin
                col <= col + 16'd1;
            end
            if (state_q == S_CLEAR) begin
                row <= '0;
            end else if (hr_fall && row != 16'hFFFF) begin
                row <= row + 16'd1;
            end
        end
    end

    // Offsets wrap when below the window, so one compare covers both bounds.
    assign dcol    = col - COL_LO;
    assign drow    = row - ROW_LO;
    assign in_win  = (dcol < WIN_W) && (drow < WIN_H);
    assign keep    = !decim_q || (!dcol[0] && !drow[0]);
    assign eol_hit = decim_q ? (col == COL_END_D) : (col == COL_END_F);
    assign eof_hit = eol_hit &&
                     (decim_q ? (row == ROW_END_D) : (row == ROW_END_F));
    assign accept  = (state_q == S_ACTIVE) && hr_r && pe_r &&
                     in_win && keep && !vs_rise;

    // Tag accepted pixels with their frame markers before the FIFO.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wp_vld   <= 1'b0;
            wp_ent   <= '0;
            sof_pend <= 1'b1;
        end else if (flush) begin
            wp_vld   <= 1'b0;
            wp_ent   <= '0;
            sof_pend <= 1'b1;
        end else begin
            wp_vld <= accept;
            wp_ent <= {sof_pend, eol_hit, eof_hit, px_r};
            if (accept) begin
                sof_pend <= 1'b0;
            end
        end
    end

    // Occupancy includes the output register, so FIFO_DEPTH is the total.
    assign mem_empty = (wr_ptr == rd_ptr);
    assign full      = (occ == OCC_FULL);
    assign xfer      = o_vld && i_rdy;
    assign load      = !mem_empty && (!o_vld || i_rdy) && !flush;
    assign wr_ok     = wp_vld && (!full || xfer);
    assign drop      = wp_vld && full && !xfer;

    // FIFO storage; no reset needed on the data array.
    always_ff @(posedge i_clk) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wp_ent;
        end
    end

    // FIFO pointers and occupancy, flushed for every frame start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_ok, xfer})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Registered first-word-fall-through output; holds while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vld  <= 1'b0;
            o_data <= '0;
            o_sof  <= 1'b0;
            o_eol  <= 1'b0;
            o_eof  <= 1'b0;
        end else if (flush) begin
            o_vld  <= 1'b0;
            o_data <= '0;
            o_sof  <= 1'b0;
            o_eol  <= 1'b0;
            o_eof  <= 1'b0;
        end else if (load) begin
            o_vld <= 1'b1;
            {o_sof, o_eol, o_eof, o_data} <= mem[rd_ptr[AW-1:0]];
        end else if (xfer) begin
            o_vld <= 1'b0;
        end
    end

    // Sticky overflow per frame and a free-running completed-frame count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf       <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            if (flush) begin
                o_ovf <= 1'b0;
            end else if (drop) begin
                o_ovf <= 1'b1;
            end
            if (xfer && o_eof) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end

    // State register plus clear timer, decimation latch and post-reset arm.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_CLEAR;
            clr_cnt <= '0;
            arm     <= 1'b0;
            decim_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (vs_rise) begin
                clr_cnt <= '0;
                arm     <= 1'b1;
                decim_q <= i_decim;
            end else if (state_q == S_CLEAR) begin
                clr_cnt <= clr_cnt + 16'd1;
            end
        end
    end

    // Next state: vsync rise restarts the frame from any state.
    always_comb begin
        state_d = state_q;
        if (vs_rise) begin
            state_d = S_CLEAR;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state_d = arm ? S_ACTIVE : S_IDLE;
                    end
                end
                S_ACTIVE: begin
                    if (wr_ok && wp_ent[DATA_W]) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign o_frame_clr = (state_q == S_CLEAR);

endmodule

// File: tb/tb_image_window_capture.sv
// Bench for image_window_capture: directed frames with a queue scoreboard
// and an independent output monitor.
module tb_image_window_capture;

    localparam int DW = 8;
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int HO = 8;
    localparam int VO = 4;
    localparam int FD = 16;
    localparam int CL = 4;
    localparam int NC = 24;
    localparam int NR = 14;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_pix_vsync;
    logic          i_pix_href;
    logic          i_pix_en;
    logic [DW-1:0] i_pix_data;
    logic          i_decim;
    logic          o_vld;
    logic          i_rdy;
    logic [DW-1:0] o_data;
    logic          o_sof;
    logic          o_eol;
    logic          o_eof;
    logic          o_frame_clr;
    logic          o_ovf;
    logic [15:0]   o_frame_cnt;

    image_window_capture #(
        .DATA_W(DW), .IMG_W(W), .IMG_H(H), .H_OFF(HO), .V_OFF(VO),
        .FIFO_DEPTH(FD), .CLR_LEN(CL)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_pix_vsync(i_pix_vsync), .i_pix_href(i_pix_href),
        .i_pix_en(i_pix_en), .i_pix_data(i_pix_data),
        .i_decim(i_decim), .o_vld(o_vld), .i_rdy(i_rdy),
        .o_data(o_data), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
        .o_frame_clr(o_frame_clr), .o_ovf(o_ovf),
        .o_frame_cnt(o_frame_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int pix_cnt = 0;
    int eol_cnt = 0;
    int t_first = 0;
    int t_out = 0;
    bit lat_arm = 0;
    bit lat_seen = 0;
    bit prev_stall = 0;
    logic [DW+2:0] prev_word = '0;
    logic [DW+2:0] exp_q[$];

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    initial begin
        i_rdy = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            case (rdy_mode)
                0: i_rdy = 1'b1;
                1: i_rdy = ((cyc % 3) == 0);
                default: i_rdy = 1'b0;
            endcase
        end
    end

    always @(negedge i_clk) begin
        logic [DW+2:0] w;
        logic [DW+2:0] cur;
        cur = {o_sof, o_eol, o_eof, o_data};
        if (!i_rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && !o_frame_clr) begin
                chk("hold_vld", 32'(o_vld), 32'd1);
                chk("hold_word", 32'(cur), 32'(prev_word));
            end
            if (o_vld && i_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out got %0h want none", cur);
                end else begin
                    w = exp_q.pop_front();
                    chk("out_word", 32'(cur), 32'(w));
                end
                pix_cnt++;
                if (o_eol) eol_cnt++;
            end
            if (lat_arm && o_vld && !lat_seen) begin
                lat_seen = 1;
                t_out = cyc;
            end
            prev_stall = o_vld && !i_rdy;
            prev_word = cur;
        end
    end

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return DW'((r % 8) * 32 + c);
    endfunction

    task automatic push_exp(input bit dec, input int limit, input int srow);
        int n;
        int nc;
        bit eol;
        bit eof;
        n = 0;
        for (int r = 0; r < NR; r++) begin
            nc = (r == srow) ? 12 : NC;
            for (int c = 0; c < nc; c++) begin
                if (c >= HO && c < HO + W && r >= VO && r < VO + H &&
                    (!dec || (((c - HO) % 2) == 0 && ((r - VO) % 2) == 0))) begin
                    eol = (c == HO + W - (dec ? 2 : 1));
                    eof = eol && (r == VO + H - (dec ? 2 : 1));
                    if (n < limit) exp_q.push_back({n == 0, eol, eof, pix(r, c)});
                    n++;
                end
            end
        end
    endtask

    task automatic send_line(input int r, input int nc, input bit gaps,
                             input int hblank);
        i_pix_href = 1'b1;
        for (int c = 0; c < nc; c++) begin
            if (gaps && (c % 5) == 2) begin
                i_pix_en = 1'b0;
                i_pix_data = 8'hEE;
                @(negedge i_clk);
            end
            i_pix_en = 1'b1;
            i_pix_data = pix(r, c);
            if (r == VO && c == HO) t_first = cyc + 1;
            @(negedge i_clk);
        end
        i_pix_href = 1'b0;
        i_pix_en = 1'b0;
        repeat (hblank) @(negedge i_clk);
    endtask

    task automatic send_frame(input int nrows, input int srow, input bit gaps,
                              input int hblank);
        for (int r = 0; r < nrows; r++)
            send_line(r, (r == srow) ? 12 : NC, gaps, hblank);
        repeat (4) @(negedge i_clk);
    endtask

    task automatic vsync_pulse(input string name);
        int t_vs;
        int first;
        int n;
        bit vbad;
        first = -1;
        n = 0;
        vbad = 0;
        i_pix_vsync = 1'b1;
        t_vs = cyc + 1;
        for (int k = 0; k < CL + 6; k++) begin
            @(negedge i_clk);
            if (o_frame_clr) begin
                if (first < 0) first = cyc;
                n++;
                if (o_vld) vbad = 1;
            end
        end
        i_pix_vsync = 1'b0;
        repeat (3) @(negedge i_clk);
        chk({name, "_clr_start"}, 32'(first), 32'(t_vs + 1));
        chk({name, "_clr_len"}, 32'(n), 32'(CL));
        chk({name, "_clr_vld"}, 32'(vbad), 32'd0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge i_clk);
        end
        chk({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (4) @(negedge i_clk);
    endtask

    task automatic clr_after_rst(input string name);
        int n;
        n = 0;
        for (int k = 0; k < CL + 4; k++) begin
            if (o_frame_clr) n++;
            @(negedge i_clk);
        end
        chk(name, 32'(n), 32'(CL));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b1;
        i_pix_vsync = 1'b0;
        i_pix_href = 1'b0;
        i_pix_en = 1'b0;
        i_pix_data = '0;
        i_decim = 1'b0;
        #3 i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_vld", 32'(o_vld), 32'd0);
        chk("rst_data", 32'({o_sof, o_eol, o_eof, o_data}), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        chk("rst_cnt", 32'(o_frame_cnt), 32'd0);
        chk("rst_clr", 32'(o_frame_clr), 32'd1);
        i_rst_n = 1'b1;
        clr_after_rst("rst_clr_len");
        repeat (3) @(negedge i_clk);

        // full window, no decimation, latency on the first pixel
        vsync_pulse("f1");
        pix_cnt = 0; eol_cnt = 0; lat_seen = 0; lat_arm = 1;
        push_exp(0, 100000, -1);
        send_frame(NR, -1, 0, 8);
        drain("f1");
        lat_arm = 0;
        chk("f1_latency", 32'(t_out), 32'(t_first + 3));
        chk("f1_pix", 32'(pix_cnt), 32'd128);
        chk("f1_eol", 32'(eol_cnt), 32'd8);
        chk("f1_cnt", 32'(o_frame_cnt), 32'd1);

        // decimated window; i_decim flip after clear must not matter
        i_decim = 1'b1;
        vsync_pulse("f2");
        i_decim = 1'b0;
        pix_cnt = 0; eol_cnt = 0;
        push_exp(1, 100000, -1);
        send_frame(NR, -1, 0, 8);
        drain("f2");
        chk("f2_pix", 32'(pix_cnt), 32'd32);
        chk("f2_eol", 32'(eol_cnt), 32'd4);
        chk("f2_cnt", 32'(o_frame_cnt), 32'd2);

        // ready 1-of-3, pix_en gaps and one short line
        rdy_mode = 1;
        vsync_pulse("f3");
        pix_cnt = 0; eol_cnt = 0;
        push_exp(0, 100000, 6);
        send_frame(NR, 6, 1, 40);
        drain("f3");
        rdy_mode = 0;
        repeat (3) @(negedge i_clk);
        chk("f3_pix", 32'(pix_cnt), 32'd116);
        chk("f3_eol", 32'(eol_cnt), 32'd7);
        chk("f3_ovf", 32'(o_ovf), 32'd0);
        chk("f3_cnt", 32'(o_frame_cnt), 32'd3);

        // ready held low for a whole frame: first FD pixels survive
        rdy_mode = 2;
        vsync_pulse("f4");
        pix_cnt = 0; eol_cnt = 0;
        push_exp(0, FD, -1);
        send_frame(NR, -1, 0, 8);
        chk("f4_ovf_set", 32'(o_ovf), 32'd1);
        chk("f4_vld_held", 32'(o_vld), 32'd1);
        rdy_mode = 0;
        drain("f4");
        chk("f4_pix", 32'(pix_cnt), 32'(FD));
        chk("f4_vld_empty", 32'(o_vld), 32'd0);
        chk("f4_ovf_sticky", 32'(o_ovf), 32'd1);
        chk("f4_cnt", 32'(o_frame_cnt), 32'd3);

        // partial frame stalled, then vsync mid-frame discards it
        rdy_mode = 2;
        vsync_pulse("f5a");
        chk("f5_ovf_clr", 32'(o_ovf), 32'd0);
        send_frame(6, -1, 0, 8);
        chk("f5_ovf_set", 32'(o_ovf), 32'd1);
        chk("f5_vld_pre", 32'(o_vld), 32'd1);
        vsync_pulse("f5b");
        rdy_mode = 0;
        repeat (2) @(negedge i_clk);
        chk("f5_vld_flushed", 32'(o_vld), 32'd0);
        chk("f5_ovf_flushed", 32'(o_ovf), 32'd0);
        chk("f5_cnt_keep", 32'(o_frame_cnt), 32'd3);
        pix_cnt = 0; eol_cnt = 0;
        push_exp(0, 100000, -1);
        send_frame(NR, -1, 0, 8);
        drain("f5");
        chk("f5_pix", 32'(pix_cnt), 32'd128);
        chk("f5_cnt", 32'(o_frame_cnt), 32'd4);

        // asynchronous reset while a pixel is waiting on the output
        rdy_mode = 2;
        vsync_pulse("f6");
        send_frame(5, -1, 0, 8);
        chk("f6_vld_pre", 32'(o_vld), 32'd1);
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("f6_rst_vld", 32'(o_vld), 32'd0);
        chk("f6_rst_data", 32'({o_sof, o_eol, o_eof, o_data}), 32'd0);
        chk("f6_rst_cnt", 32'(o_frame_cnt), 32'd0);
        chk("f6_rst_ovf", 32'(o_ovf), 32'd0);
        chk("f6_rst_clr", 32'(o_frame_clr), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        rdy_mode = 0;
        clr_after_rst("f6_clr_len");
        chk("f6_vld_after", 32'(o_vld), 32'd0);
        chk("end_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
